// File: rtl/run_sequencer_if.sv
// Host-side request/response handshake bundle for run_sequencer.
// master = host/bench, slave = sequencer.
interface run_sequencer_if #(
   parameter int unsigned PW = 2,
   parameter int unsigned CW = 16
);
   logic          ReqValid;
   logic [PW-1:0] ReqProg;
   logic          ReqReady;
   logic          RspValid;
   logic          RspReady;
   logic [CW-1:0] RspCycles;
   logic [PW-1:0] RspProg;
   logic          RspTimeout;

   modport master (
      output ReqValid, ReqProg, RspReady,
      input  ReqReady, RspValid, RspCycles, RspProg, RspTimeout
   );

   modport slave (
      input  ReqValid, ReqProg, RspReady,
      output ReqReady, RspValid, RspCycles, RspProg, RspTimeout
   );
endinterface

// File: rtl/run_sequencer.sv
// Run controller: starts a processor program, times it until Ack, reports the result.
// Optional watchdog compiled in with `define RUN_SEQ_TIMEOUT_EN.
module run_sequencer #(
   parameter int unsigned    PW           = 2,
   parameter int unsigned    CW           = 16,
   parameter int unsigned    START_CYCLES = 2,
   parameter logic [CW-1:0]  TIMEOUT      = 16'd60000
) (
   input  logic                Clk,
   input  logic                Reset_n,
   run_sequencer_if.slave      bus,
   output logic                Start,
   output logic [PW-1:0]       ProgSel,
   input  logic                Ack,
   output logic                Busy
);

   localparam int unsigned SCW = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
   localparam logic [SCW-1:0] START_LAST = SCW'(START_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, START, RUN, REPORT} state_t;

   state_t         state, stateNext;
   logic [SCW-1:0] startCnt, startCntNext;
   logic [CW-1:0]  cycleCnt, cycleCntNext;
   logic [PW-1:0]  progQ, progNext;
   logic [CW-1:0]  rspCyclesQ, rspCyclesNext;
   logic           rspTimeoutQ, rspTimeoutNext;
   logic           reqReadyQ, startQ, busyQ, rspValidQ;

   always_comb begin
      stateNext      = state;
      startCntNext   = startCnt;
      cycleCntNext   = cycleCnt;
      progNext       = progQ;
      rspCyclesNext  = rspCyclesQ;
      rspTimeoutNext = rspTimeoutQ;
      case (state)
         IDLE: begin
            if (bus.ReqValid && reqReadyQ) begin
               progNext     = bus.ReqProg;
               startCntNext = '0;
               stateNext    = START;
            end
         end
         START: begin
            if (startCnt == START_LAST) begin
               cycleCntNext = '0;
               stateNext    = RUN;
            end else begin
               startCntNext = startCnt + 1'b1;
            end
         end
         RUN: begin
            // Halt is tested first so it wins over a same-cycle watchdog hit.
            if (Ack) begin
               rspCyclesNext  = cycleCnt;
               rspTimeoutNext = 1'b0;
               stateNext      = REPORT;
            end
`ifdef RUN_SEQ_TIMEOUT_EN
            else if (cycleCnt == TIMEOUT - 1'b1) begin
               rspCyclesNext  = TIMEOUT;
               rspTimeoutNext = 1'b1;
               stateNext      = REPORT;
            end
`endif
            else if (cycleCnt != '1) begin
               cycleCntNext = cycleCnt + 1'b1;
            end
         end
         REPORT: begin
            if (bus.RspReady && rspValidQ) stateNext = IDLE;
         end
         default: stateNext = IDLE;
      endcase
   end

   // Handshake outputs are registered from the next state so they line up with it.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state       <= IDLE;
         startCnt    <= '0;
         cycleCnt    <= '0;
         progQ       <= '0;
         rspCyclesQ  <= '0;
         rspTimeoutQ <= 1'b0;
         reqReadyQ   <= 1'b1;
         startQ      <= 1'b0;
         busyQ       <= 1'b0;
         rspValidQ   <= 1'b0;
      end else begin
         state       <= stateNext;
         startCnt    <= startCntNext;
         cycleCnt    <= cycleCntNext;
         progQ       <= progNext;
         rspCyclesQ  <= rspCyclesNext;
         rspTimeoutQ <= rspTimeoutNext;
         reqReadyQ   <= (stateNext == IDLE);
         startQ      <= (stateNext == START);
         busyQ       <= (stateNext != IDLE);
         rspValidQ   <= (stateNext == REPORT);
      end
   end

   assign Start         = startQ;
   assign Busy          = busyQ;
   assign ProgSel       = progQ;
   assign bus.ReqReady  = reqReadyQ;
   assign bus.RspValid  = rspValidQ;
   assign bus.RspCycles = rspCyclesQ;
   assign bus.RspProg   = progQ;
`ifdef RUN_SEQ_TIMEOUT_EN
   assign bus.RspTimeout = rspTimeoutQ;
`else
   // Without the watchdog the flag is constant; TIMEOUT is referenced only to keep it bound.
   assign bus.RspTimeout = (TIMEOUT == '0) & 1'b0 & rspTimeoutQ;
`endif

endmodule

// File: tb/tb_run_sequencer.sv
// Scoreboard bench for run_sequencer: directed runs push expected records,
// a monitor pops and compares them on each response handshake.
module tb_run_sequencer;

   logic          Clk = 1'b0;
   logic          Reset_n;
   logic          Start;
   logic [1:0]    ProgSel;
   logic          Ack;
   logic          Busy;

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic [15:0] cycles;
      logic [1:0]  prog;
      logic        tmo;
   } rsp_t;

   rsp_t sb[$];
   rsp_t monE;

   run_sequencer_if #(.PW(2), .CW(16)) bus ();

   run_sequencer #(
      .PW(2), .CW(16), .START_CYCLES(2), .TIMEOUT(16'd100)
   ) dut (
      .Clk(Clk), .Reset_n(Reset_n), .bus(bus.slave),
      .Start(Start), .ProgSel(ProgSel), .Ack(Ack), .Busy(Busy)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every accepted response must match the oldest expectation.
   always @(negedge Clk) begin
      if (Reset_n === 1'b1 && bus.RspValid === 1'b1 && bus.RspReady === 1'b1) begin
         if (sb.size() == 0) begin
            check("rsp_unexpected", 32'd1, 32'd0);
         end else begin
            monE = sb.pop_front();
            check("rsp_cycles",  32'(bus.RspCycles),  32'(monE.cycles));
            check("rsp_prog",    32'(bus.RspProg),    32'(monE.prog));
            check("rsp_timeout", 32'(bus.RspTimeout), 32'(monE.tmo));
         end
      end
   end

   task automatic pushExp(input logic [15:0] c, input logic [1:0] p, input logic t);
      rsp_t e;
      e.cycles = c; e.prog = p; e.tmo = t;
      sb.push_back(e);
   endtask

   // Accept a request, then check both START cycles; returns 1 time unit into RUN cycle 0.
   task automatic startProg(input logic [1:0] p, input logic stale);
      @(posedge Clk); #1;
      bus.ReqValid = 1'b1; bus.ReqProg = p; Ack = stale;
      @(negedge Clk) check("req_ready_idle", 32'(bus.ReqReady), 32'd1);
      @(posedge Clk); #1;
      bus.ReqValid = 1'b0; bus.ReqProg = 2'd0;
      for (int i = 0; i < 2; i++) begin
         @(negedge Clk);
         check("start_hi", 32'(Start), 32'd1);
         check("prog_sel_start", 32'(ProgSel), 32'(p));
         check("busy_start", 32'(Busy), 32'd1);
         check("req_ready_start", 32'(bus.ReqReady), 32'd0);
         @(posedge Clk); #1;
      end
      Ack = 1'b0;
   endtask

   task automatic runCycles(input int n, input logic [1:0] p);
      for (int i = 0; i < n; i++) begin
         @(negedge Clk);
         check("start_lo_run", 32'(Start), 32'd0);
         check("rsp_valid_run", 32'(bus.RspValid), 32'd0);
         check("prog_sel_run", 32'(ProgSel), 32'(p));
         @(posedge Clk); #1;
      end
   endtask

   // Drive the deciding RUN cycle; ends at the negedge of the first REPORT cycle.
   task automatic finishRun(input logic ackLast);
      Ack = ackLast;
      @(negedge Clk) check("rsp_valid_last_run", 32'(bus.RspValid), 32'd0);
      @(posedge Clk); #1;
      Ack = 1'b0;
      @(negedge Clk);
      check("rsp_valid_report", 32'(bus.RspValid), 32'd1);
      check("busy_report", 32'(Busy), 32'd1);
   endtask

   task automatic rspDone();
      @(posedge Clk); #1;
      @(negedge Clk);
      check("rsp_valid_drop", 32'(bus.RspValid), 32'd0);
      check("req_ready_back", 32'(bus.ReqReady), 32'd1);
      check("busy_idle", 32'(Busy), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      Reset_n = 1'b1; Ack = 1'b0;
      bus.ReqValid = 1'b0; bus.ReqProg = 2'd0; bus.RspReady = 1'b1;
      #3 Reset_n = 1'b0;
      repeat (3) @(posedge Clk);
      #1;
      check("rst_outputs", {28'd0, bus.ReqReady, Busy, Start, bus.RspValid}, 32'b1000);
      check("rst_fields", {13'd0, ProgSel, bus.RspCycles, bus.RspProg, bus.RspTimeout}, 32'd0);
      Reset_n = 1'b1;
      for (int i = 0; i < 10; i++)
         @(negedge Clk) check("idle_after_reset",
                              {28'd0, bus.ReqReady, Busy, Start, bus.RspValid}, 32'b1000);

      // Basic run: program 2, halt 37 cycles after Start falls.
      startProg(2'd2, 1'b0);
      pushExp(16'd37, 2'd2, 1'b0);
      runCycles(37, 2'd2);
      finishRun(1'b1);
      rspDone();

      // Backpressure: result must hold and new requests must be ignored.
      bus.RspReady = 1'b0;
      startProg(2'd1, 1'b0);
      pushExp(16'd10, 2'd1, 1'b0);
      runCycles(10, 2'd1);
      finishRun(1'b1);
      for (int i = 0; i < 20; i++) begin
         @(posedge Clk); #1;
         bus.ReqValid = 1'b1; bus.ReqProg = 2'd3;
         @(negedge Clk);
         check("bp_valid", 32'(bus.RspValid), 32'd1);
         check("bp_cycles", 32'(bus.RspCycles), 32'd10);
         check("bp_prog", 32'(bus.RspProg), 32'd1);
         check("bp_timeout", 32'(bus.RspTimeout), 32'd0);
         check("bp_req_ready", 32'(bus.ReqReady), 32'd0);
      end
      @(posedge Clk); #1;
      bus.ReqValid = 1'b0; bus.RspReady = 1'b1;
      @(negedge Clk);
      rspDone();
      check("bp_req_ignored", 32'(ProgSel), 32'd1);

      // Stale Ack held through START must not end the run.
      startProg(2'd3, 1'b1);
      pushExp(16'd5, 2'd3, 1'b0);
      runCycles(5, 2'd3);
      finishRun(1'b1);
      rspDone();

`ifdef RUN_SEQ_TIMEOUT_EN
      startProg(2'd0, 1'b0);
      pushExp(16'd100, 2'd0, 1'b1);
      runCycles(99, 2'd0);
      finishRun(1'b0);
      rspDone();
      // Ack on the watchdog cycle: halt wins.
      startProg(2'd1, 1'b0);
      pushExp(16'd99, 2'd1, 1'b0);
      runCycles(99, 2'd1);
      finishRun(1'b1);
      rspDone();
`else
      begin
         bit sawRsp;
         sawRsp = 1'b0;
         startProg(2'd0, 1'b0);
         for (int i = 0; i < 1000; i++)
            @(negedge Clk) if (bus.RspValid !== 1'b0) sawRsp = 1'b1;
         check("no_watchdog_rsp", 32'(sawRsp), 32'd0);
         check("still_busy", 32'(Busy), 32'd1);
         @(posedge Clk); #1 Reset_n = 1'b0;
         @(posedge Clk); #1 Reset_n = 1'b1;
      end
`endif

      // Reset asserted in RUN cycle 12 clears outputs immediately.
      startProg(2'd2, 1'b0);
      runCycles(12, 2'd2);
      Reset_n = 1'b0;
      #1;
      check("midrst_outputs", {28'd0, bus.ReqReady, Busy, Start, bus.RspValid}, 32'b1000);
      check("midrst_progsel", 32'(ProgSel), 32'd0);
      @(posedge Clk); #1 Reset_n = 1'b1;
      startProg(2'd2, 1'b0);
      pushExp(16'd3, 2'd2, 1'b0);
      runCycles(3, 2'd2);
      finishRun(1'b1);
      rspDone();

      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/run_sequencer.md
# run_sequencer

Run controller directly upstream of the processor top level. It accepts program-run requests from the host or bench side and drives the processor's `Start` and program-select lines. It then watches the processor's `Ack` (halt) flag, measures the run length in clock cycles, and returns a result record through a valid/ready handshake. It also flags runs that never halt (watchdog).

## Interface
Parameters:
- `PW`, 2: width of the program index (selects one of 2^PW program images).
- `CW`, 16: width of the cycle counter and `RspCycles`.
- `START_CYCLES`, 2: number of cycles `Start` is held high per run; legal range ≥1.
- `TIMEOUT`, 16'd60000: watchdog limit in RUN cycles; legal range 1 .. 2^CW-1.

Ports:
- `Clk`  in  1  clock, posedge only.
- `Reset_n`  in  1  reset; one clock; reset is asynchronous and active-low.
- `ReqValid`  in  1  run request present.
- `ReqProg`  in  PW  program index of the request.
- `ReqReady`  out  1  sequencer can accept a request.
- `Start`  out  1  to processor `Start`.
- `ProgSel`  out  PW  registered program index, held for the whole run and report.
- `Ack`  in  1  processor halt flag; combinational from the processor and may glitch between runs.
- `RspValid`  out  1  result record valid.
- `RspReady`  in  1  consumer takes the result.
- `RspCycles`  out  CW  run length in cycles.
- `RspProg`  out  PW  program index of this result.
- `RspTimeout`  out  1  1 = watchdog expired, not halted.
- `Busy`  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, START, RUN, REPORT. Encoding is free.
- IDLE:
  - `ReqReady`=1.
  - On `ReqValid && ReqReady`, latch `ReqProg` into `ProgSel`/`RspProg`, clear the start counter, and go to START.
- START:
  - `Start`=1 for exactly `START_CYCLES` consecutive cycles.
  - `Ack` is ignored in this state; the processor is being reinitialised.
  - After the last START cycle, go to RUN with the cycle counter at 0.
- RUN:
  - `Start`=0.
  - Each cycle with `Ack`=0, the counter increments by 1.
  - The first cycle sampling `Ack`=1 moves to REPORT with `RspCycles` = counter value at that edge (the count of Ack-low RUN cycles) and `RspTimeout`=0.
- Watchdog (see Configuration): if `Ack`=0 and the counter equals `TIMEOUT`-1, go to REPORT with `RspCycles`=`TIMEOUT` and `RspTimeout`=1.
- Counter arithmetic: unsigned, CW bits, saturates at all-ones and never wraps.
- REPORT:
  - `RspValid`=1.
  - `RspCycles`, `RspProg` and `RspTimeout` are stable until the handshake.
  - On `RspValid && RspReady`, go to IDLE; `RspValid` drops the next cycle.
- Requests are never accepted outside IDLE; `ReqReady`=0 there, and `ReqValid` may stay high without effect.
- Simultaneous `Ack`=1 and watchdog hit in the same cycle: halt wins (`RspTimeout`=0).

## Timing
- Reset values: state=IDLE, `ReqReady`=1, `Start`=0, `ProgSel`=0, `RspValid`=0, `RspCycles`=0, `RspProg`=0, `RspTimeout`=0, `Busy`=0.
- Reset asserted mid-run or mid-report: all outputs take their reset values immediately (asynchronous). Any pending result is discarded.
- All outputs are registered; there is no combinational path from any input to any output.
- Latency, request to `Start` high: 1 cycle (accept edge N, `Start`=1 in cycle N+1).
- `Ack` high in RUN cycle K (RUN cycles numbered from 0): `RspValid`=1 in the next cycle with `RspCycles`=K.
- Minimum request-to-request spacing: 1 + `START_CYCLES` + RUN cycles + 1 + response wait.

## Configuration
- `RUN_SEQ_TIMEOUT_EN` defined:
  - Watchdog compiled in as described above.
  - Timed-out runs report `RspTimeout`=1.
- `RUN_SEQ_TIMEOUT_EN` undefined:
  - No watchdog logic; RUN waits for `Ack` indefinitely.
  - The counter saturates at 2^CW-1.
  - `RspTimeout` is tied to 0, and `TIMEOUT` is unused.

## Test plan
- Reset check: release `Reset_n`, no request -> `ReqReady`=1, `Busy`=0, `Start`=0, `RspValid`=0 for 10 cycles.
- Basic run: `ReqProg`=2 accepted at edge N; `Ack` model raises `Ack` 37 cycles after `Start` falls.
  - Required: `Start` high exactly 2 cycles from N+1.
  - Required: `RspValid` with `RspCycles`=37, `RspProg`=2, `RspTimeout`=0.
  - Required: `ProgSel`=2 throughout.
- Backpressure: hold `RspReady`=0 for 20 cycles after `RspValid` -> fields unchanged, `ReqReady`=0, and a new `ReqValid` is ignored. On `RspReady`=1, return to IDLE next cycle.
- Stale Ack: `Ack` held 1 through START, then dropped; halt after 5 cycles -> Ack during START ignored, `RspCycles`=5.
- Watchdog (macro defined, `TIMEOUT`=100): `Ack` never rises -> `RspValid` after 100 RUN cycles with `RspCycles`=100 and `RspTimeout`=1. Without the macro, no response within 1000 cycles.
- Reset mid-run: assert `Reset_n`=0 at RUN cycle 12 -> `Start`, `Busy` and `RspValid` at 0 the same cycle. After release, a new request with `Ack` after 3 cycles reports `RspCycles`=3.
